// File: rtl/fp_to_int_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int_sched
// Purpose  : Two-port round-robin scheduler for the shared two-stage
//            FP-to-integer conversion datapath.
//            S1 holds the registered operands that feed the combinational
//            datapath. S2 is the output buffer that captures result/fflags.
//            The block stalls on output backpressure and kills ops that are
//            the redirected op or younger.
// Revision : 1.0 - initial release
// ============================================================================
module fp_to_int_sched #(
    parameter int TAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_src,
    input  logic             req0_fmt,
    input  logic [2:0]       req0_rm,
    input  logic [1:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_src,
    input  logic             req1_fmt,
    input  logic [2:0]       req1_rm,
    input  logic [1:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             dp_valid,
    output logic [63:0]      dp_src,
    output logic             dp_fmt,
    output logic [2:0]       dp_rm,
    output logic [1:0]       dp_op,
    input  logic [63:0]      dp_result,
    input  logic [4:0]       dp_fflags,

    input  logic             flush_valid,
    input  logic [TAG_W-1:0] flush_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [4:0]       out_fflags,
    output logic [TAG_W-1:0] out_tag
);

    // True when tag t is the flushed op or younger. The MSB is the ROB wrap
    // flag: a differing flag inverts the sense of the index comparison.
    function automatic logic kill_f(input logic [TAG_W-1:0] t,
                                    input logic [TAG_W-1:0] f);
        logic older_or_younger;
        older_or_younger = (t[TAG_W-1] ^ f[TAG_W-1]) ^ (t[TAG_W-2:0] > f[TAG_W-2:0]);
        return older_or_younger | (t == f);
    endfunction

    // Control state (reset)
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             prio_q,     prio_d;

    // Data state (not reset)
    logic [63:0]      s1_src_q,    s1_src_d;
    logic             s1_fmt_q,    s1_fmt_d;
    logic [2:0]       s1_rm_q,     s1_rm_d;
    logic [1:0]       s1_op_q,     s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;
    logic [63:0]      s2_data_q,   s2_data_d;
    logic [4:0]       s2_fflags_q, s2_fflags_d;
    logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

    // Handshake / arbitration wires
    logic             s1_live, s2_live;
    logic             s2_free, s1_adv, in_ready;
    logic             grant0, grant1, accept, in_kill;
    logic [TAG_W-1:0] in_tag;

    // Pipeline flow control, arbitration and next-state computation
    always_comb begin
        s1_live  = s1_valid_q & ~(flush_valid & kill_f(s1_tag_q, flush_tag));
        s2_live  = s2_valid_q & ~(flush_valid & kill_f(s2_tag_q, flush_tag));
        s2_free  = ~s2_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_free;
        in_ready = (~s1_valid_q | s1_adv) & ~reset;

        grant0   = req0_valid & (~req1_valid | ~prio_q);
        grant1   = req1_valid & (~req0_valid |  prio_q);
        accept   = in_ready & (grant0 | grant1);
        in_tag   = grant1 ? req1_tag : req0_tag;
        in_kill  = flush_valid & kill_f(in_tag, flush_tag);

        // Defaults: hold
        prio_d      = prio_q;
        s1_valid_d  = s1_live;
        s2_valid_d  = s2_live;
        s1_src_d    = s1_src_q;
        s1_fmt_d    = s1_fmt_q;
        s1_rm_d     = s1_rm_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;
        s2_data_d   = s2_data_q;
        s2_fflags_d = s2_fflags_q;
        s2_tag_d    = s2_tag_q;

        // S2: refill from S1 (a killed S1 op leaves a bubble), or drain
        if (s1_adv) begin
            s2_valid_d  = s1_live;
            s2_data_d   = dp_result;
            s2_fflags_d = dp_fflags;
            s2_tag_d    = s1_tag_q;
        end else if (out_ready) begin
            s2_valid_d  = 1'b0;
        end

        // S1: load the winner; a killed incoming op is consumed but dropped
        if (accept) begin
            s1_valid_d = ~in_kill;
            s1_src_d   = grant1 ? req1_src : req0_src;
            s1_fmt_d   = grant1 ? req1_fmt : req0_fmt;
            s1_rm_d    = grant1 ? req1_rm  : req0_rm;
            s1_op_d    = grant1 ? req1_op  : req0_op;
            s1_tag_d   = in_tag;
            prio_d     = ~grant1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Valid bits and round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prio_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            prio_q     <= prio_d;
        end
    end

    // Stage data registers
    always_ff @(posedge clock) begin
        s1_src_q    <= s1_src_d;
        s1_fmt_q    <= s1_fmt_d;
        s1_rm_q     <= s1_rm_d;
        s1_op_q     <= s1_op_d;
        s1_tag_q    <= s1_tag_d;
        s2_data_q   <= s2_data_d;
        s2_fflags_q <= s2_fflags_d;
        s2_tag_q    <= s2_tag_d;
    end

    assign req0_ready = in_ready & grant0;
    assign req1_ready = in_ready & grant1;

    assign dp_valid   = s1_live;
    assign dp_src     = s1_src_q;
    assign dp_fmt     = s1_fmt_q;
    assign dp_rm      = s1_rm_q;
    assign dp_op      = s1_op_q;

    assign out_valid  = s2_live;
    assign out_data   = s2_data_q;
    assign out_fflags = s2_fflags_q;
    assign out_tag    = s2_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_int_sched
// Purpose  : Directed scoreboard bench for fp_to_int_sched. A stub datapath
//            derives result/fflags from the S1 operands; each op's fields
//            are derived from its tag so the expected output is known.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_to_int_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_fmt;
    logic [63:0] req0_src;
    logic [2:0]  req0_rm;
    logic [1:0]  req0_op;
    logic [7:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_fmt;
    logic [63:0] req1_src;
    logic [2:0]  req1_rm;
    logic [1:0]  req1_op;
    logic [7:0]  req1_tag;
    logic        dp_valid, dp_fmt;
    logic [63:0] dp_src, dp_result;
    logic [2:0]  dp_rm;
    logic [1:0]  dp_op;
    logic [4:0]  dp_fflags;
    logic        flush_valid;
    logic [7:0]  flush_tag;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_fflags;
    logic [7:0]  out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  f;
        logic [7:0]  t;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    fp_to_int_sched #(.TAG_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src(req0_src),
        .req0_fmt(req0_fmt), .req0_rm(req0_rm), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src(req1_src),
        .req1_fmt(req1_fmt), .req1_rm(req1_rm), .req1_op(req1_op), .req1_tag(req1_tag),
        .dp_valid(dp_valid), .dp_src(dp_src), .dp_fmt(dp_fmt), .dp_rm(dp_rm), .dp_op(dp_op),
        .dp_result(dp_result), .dp_fflags(dp_fflags),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fflags(out_fflags), .out_tag(out_tag)
    );

    // Stub datapath: result = src with bit63 flipped for doubles; fflags = {op, rm}
    assign dp_result = dp_src ^ {dp_fmt, 63'b0};
    assign dp_fflags = {dp_op, dp_rm};

    // Operand encoding per tag: fmt = tag[6], op = tag[4:3], rm = tag[2:0]
    function automatic logic [63:0] src_of(input logic [7:0] t);
        if (t == 8'h05) return 64'h0000_0000_0000_002A;
        return {t, 40'h0, 8'h5A, t};
    endfunction

    function automatic exp_t exp_of(input logic [7:0] t);
        exp_t e;
        e.d = src_of(t) ^ {t[6], 63'b0};
        e.f = t[4:0];
        e.t = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // One cycle: drive just after posedge, check readies at negedge and
    // queue an expected result for each op that should reach the output.
    task automatic step(input logic r,
                        input logic v0, input logic [7:0] t0, input logic e0, input logic p0,
                        input logic v1, input logic [7:0] t1, input logic e1, input logic p1,
                        input logic ordy, input logic fl, input logic [7:0] ft);
        @(posedge clock);
        #1;
        reset       = r;
        req0_valid  = v0; req0_tag = t0; req0_src = src_of(t0);
        req0_fmt    = t0[6]; req0_op = t0[4:3]; req0_rm = t0[2:0];
        req1_valid  = v1; req1_tag = t1; req1_src = src_of(t1);
        req1_fmt    = t1[6]; req1_op = t1[4:3]; req1_rm = t1[2:0];
        out_ready   = ordy;
        flush_valid = fl;
        flush_tag   = ft;
        @(negedge clock);
        chk("req0_ready", {63'b0, req0_ready}, {63'b0, e0});
        chk("req1_ready", {63'b0, req1_ready}, {63'b0, e1});
        if (p0) sb.push_back(exp_of(t0));
        if (p1) sb.push_back(exp_of(t1));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ordy, 1'b0, 8'h00);
    endtask

    task automatic flush_idle(input logic ordy, input logic [7:0] ft);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ordy, 1'b1, ft);
    endtask

    // Output monitor: every transfer must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got tag %h expected none", out_tag);
            end else begin
                mon_e = sb.pop_front();
                if ({out_data, out_fflags, out_tag} !== mon_e) begin
                    errors++;
                    $display("FAIL out_result got %h/%h/%h expected %h/%h/%h",
                             out_data, out_fflags, out_tag, mon_e.d, mon_e.f, mon_e.t);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_src = 0; req0_fmt = 0; req0_rm = 0; req0_op = 0; req0_tag = 0;
        req1_valid = 0; req1_src = 0; req1_fmt = 0; req1_rm = 0; req1_op = 0; req1_tag = 0;
        out_ready = 0; flush_valid = 0; flush_tag = 0;

        // Reset: requests present but readies and valids low
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 8'h01, 0, 0, 1, 8'h02, 0, 0, 1, 0, 8'h00);
            chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
            chk("rst_dp_valid",  {63'b0, dp_valid},  64'd0);
        end

        // Round-robin: grants 0,1,0,1; losers keep their request up
        step(0, 1, 8'h20, 1, 1, 1, 8'h40, 0, 0, 1, 0, 8'h00);
        chk("rr_dp_valid0", {63'b0, dp_valid}, 64'd0);
        step(0, 1, 8'h21, 0, 0, 1, 8'h40, 1, 1, 1, 0, 8'h00);
        chk("rr_dp_valid1", {63'b0, dp_valid}, 64'd1);
        chk("rr_dp_src",    dp_src, src_of(8'h20));
        step(0, 1, 8'h21, 1, 1, 1, 8'h41, 0, 0, 1, 0, 8'h00);
        step(0, 1, 8'h22, 0, 0, 1, 8'h41, 1, 1, 1, 0, 8'h00);
        idle(1); idle(1); idle(1);
        chk("rr_drained", {63'b0, out_valid}, 64'd0);

        // Single op on port 0: tag 0x05, result 0x2A, two cycles later
        step(0, 1, 8'h05, 1, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        chk("one_out_valid0", {63'b0, out_valid}, 64'd0);
        idle(1);
        chk("one_dp_valid", {63'b0, dp_valid}, 64'd1);
        chk("one_dp_src",   dp_src, 64'h2A);
        chk("one_out_valid1", {63'b0, out_valid}, 64'd0);
        idle(1);
        chk("one_out_valid2", {63'b0, out_valid}, 64'd1);
        chk("one_out_data",   out_data, 64'h2A);
        chk("one_out_tag",    {56'b0, out_tag}, 64'h05);
        idle(1);
        chk("one_out_valid3", {63'b0, out_valid}, 64'd0);

        // Backpressure: three ops, out_ready low from the second cycle
        step(0, 1, 8'h11, 1, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        step(0, 1, 8'h12, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 8'h13, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_out_tag",   {56'b0, out_tag}, 64'h11);
            chk("bp_out_data",  out_data, exp_of(8'h11).d);
            chk("bp_dp_valid",  {63'b0, dp_valid}, 64'd1);
            chk("bp_dp_src",    dp_src, src_of(8'h12));
        end
        step(0, 1, 8'h13, 1, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        idle(1); idle(1); idle(1);
        chk("bp_drained", {63'b0, out_valid}, 64'd0);

        // Flush age: S2=0x03 survives, S1=0x07 killed by flush 0x04
        step(0, 1, 8'h03, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(0, 1, 8'h07, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        flush_idle(0, 8'h04);
        chk("fa_out_valid", {63'b0, out_valid}, 64'd1);
        chk("fa_out_tag",   {56'b0, out_tag}, 64'h03);
        chk("fa_dp_killed", {63'b0, dp_valid}, 64'd0);
        idle(1);
        chk("fa_dp_gone",   {63'b0, dp_valid}, 64'd0);
        idle(1);
        chk("fa_drained",   {63'b0, out_valid}, 64'd0);

        // Flush kills both stages while out_ready is high: no transfer
        step(0, 1, 8'h06, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        step(0, 1, 8'h08, 1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        flush_idle(1, 8'h05);
        chk("fk_out_gated", {63'b0, out_valid}, 64'd0);
        chk("fk_dp_gated",  {63'b0, dp_valid},  64'd0);
        idle(1);
        chk("fk_out_gone",  {63'b0, out_valid}, 64'd0);
        chk("fk_dp_gone",   {63'b0, dp_valid},  64'd0);

        // Wrap: S1=0x81 is younger than flush 0x7F (flag differs)
        step(0, 0, 8'h00, 0, 0, 1, 8'h81, 1, 0, 1, 0, 8'h00);
        flush_idle(1, 8'h7F);
        chk("wr_dp_killed", {63'b0, dp_valid}, 64'd0);
        idle(1);
        chk("wr_out_none",  {63'b0, out_valid}, 64'd0);
        idle(1);

        // Race: incoming tag equals flush tag -> handshaken, dropped
        step(0, 1, 8'h10, 1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h10);
        idle(1);
        chk("rc_dp_none",  {63'b0, dp_valid}, 64'd0);
        idle(1);
        chk("rc_out_none", {63'b0, out_valid}, 64'd0);

        // Reset mid-flight: both stages full, pointer favours port 1
        step(0, 1, 8'h31, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(0, 1, 8'h32, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        step(1, 1, 8'h50, 0, 0, 1, 8'h60, 0, 0, 0, 0, 8'h00);
        chk("mr_full_out", {63'b0, out_valid}, 64'd1);
        chk("mr_full_dp",  {63'b0, dp_valid},  64'd1);
        step(0, 1, 8'h50, 1, 1, 1, 8'h60, 0, 0, 1, 0, 8'h00);
        chk("mr_out_dropped", {63'b0, out_valid}, 64'd0);
        chk("mr_dp_dropped",  {63'b0, dp_valid},  64'd0);
        step(0, 0, 8'h00, 0, 0, 1, 8'h60, 1, 1, 1, 0, 8'h00);
        idle(1); idle(1); idle(1);
        chk("mr_drained", {63'b0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
